// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with operand select, ALU, branch resolve and registered MEM handoff.
module ex_alu #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y
);
    always_comb begin
        o_y = i_a + i_b;
        case (i_op)
            4'b1000: o_y = i_a - i_b;
            4'b0001: o_y = i_a << i_b[4:0];
            4'b0010: o_y = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            4'b0011: o_y = {{(XLEN-1){1'b0}}, i_a < i_b};
            4'b0100: o_y = i_a ^ i_b;
            4'b0101: o_y = i_a >> i_b[4:0];
            4'b1101: o_y = $unsigned($signed(i_a) >>> i_b[4:0]);
            4'b0110: o_y = i_a | i_b;
            4'b0111: o_y = i_a & i_b;
            default: o_y = i_a + i_b;
        endcase
    end
endmodule

module ex_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_id_valid,
    output logic            o_id_ready,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_rs1_data,
    input  logic [XLEN-1:0] i_id_rs2_data,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic [RD_W-1:0] i_id_rd,
    input  logic [3:0]      i_id_alu_op,
    input  logic            i_id_op_a_sel,
    input  logic            i_id_op_b_sel,
    input  logic            i_id_is_branch,
    input  logic            i_id_is_jal,
    input  logic            i_id_is_jalr,
    input  logic [2:0]      i_id_funct3,
    input  logic            i_id_reg_we,
    input  logic            i_id_mem_re,
    input  logic            i_id_mem_we,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_result,
    output logic [XLEN-1:0] o_ex_store_data,
    output logic [RD_W-1:0] o_ex_rd,
    output logic            o_ex_reg_we,
    output logic            o_ex_mem_re,
    output logic            o_ex_mem_we,
    output logic [2:0]      o_ex_funct3,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc
);
    logic            ex_valid_q, ex_valid_d, redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] result_q, result_d, store_data_q, store_data_d, redirect_pc_q, redirect_pc_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            reg_we_q, reg_we_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] op_a, op_b, alu_y, jalr_sum;
    logic            accept, cond, taken;

    assign op_a = i_id_op_a_sel ? i_id_pc : i_id_rs1_data;
    assign op_b = i_id_op_b_sel ? i_id_imm : i_id_rs2_data;

    ex_alu #(.XLEN(XLEN)) u_alu (.i_op(i_id_alu_op), .i_a(op_a), .i_b(op_b), .o_y(alu_y));

    assign o_id_ready = (!ex_valid_q || i_ex_ready) && !redirect_valid_q && !i_flush;
    assign accept     = i_id_valid && o_id_ready;
    assign jalr_sum   = i_id_rs1_data + i_id_imm;

    always_comb begin
        cond = i_id_funct3[2:1] == 2'b00 ? (i_id_rs1_data == i_id_rs2_data) ^ i_id_funct3[0] :
               i_id_funct3[2:1] == 2'b10 ? ($signed(i_id_rs1_data) < $signed(i_id_rs2_data)) ^ i_id_funct3[0] :
               i_id_funct3[2:1] == 2'b11 ? (i_id_rs1_data < i_id_rs2_data) ^ i_id_funct3[0] : 1'b0;
        taken            = i_id_is_jal || i_id_is_jalr || (i_id_is_branch && cond);
        ex_valid_d       = !i_flush && (accept || (ex_valid_q && !i_ex_ready));
        redirect_valid_d = !i_flush && accept && taken;
        result_d         = !accept ? result_q : (i_id_is_jal || i_id_is_jalr) ? i_id_pc + 32'd4 : alu_y;
        store_data_d     = accept ? i_id_rs2_data : store_data_q;
        rd_d             = accept ? i_id_rd : rd_q;
        reg_we_d         = accept ? i_id_reg_we && (i_id_rd != '0) : reg_we_q;
        mem_re_d         = accept ? i_id_mem_re : mem_re_q;
        mem_we_d         = accept ? i_id_mem_we : mem_we_q;
        funct3_d         = accept ? i_id_funct3 : funct3_q;
        redirect_pc_d    = !accept ? redirect_pc_q :
                           i_id_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : i_id_pc + i_id_imm;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            result_q         <= '0;
            store_data_q     <= '0;
            rd_q             <= '0;
            reg_we_q         <= 1'b0;
            mem_re_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            funct3_q         <= '0;
            redirect_pc_q    <= '0;
        end else begin
            ex_valid_q       <= ex_valid_d;
            redirect_valid_q <= redirect_valid_d;
            result_q         <= result_d;
            store_data_q     <= store_data_d;
            rd_q             <= rd_d;
            reg_we_q         <= reg_we_d;
            mem_re_q         <= mem_re_d;
            mem_we_q         <= mem_we_d;
            funct3_q         <= funct3_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign o_ex_valid       = ex_valid_q;
    assign o_redirect_valid = redirect_valid_q;
    assign o_ex_result      = result_q;
    assign o_ex_store_data  = store_data_q;
    assign o_ex_rd          = rd_q;
    assign o_ex_reg_we      = reg_we_q;
    assign o_ex_mem_re      = mem_re_q;
    assign o_ex_mem_we      = mem_we_q;
    assign o_ex_funct3      = funct3_q;
    assign o_redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven directed checks of ex_stage plus handshake/flush/reset sequences.
module tb_ex_stage;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        id_valid = 1'b0, id_ready, ex_ready = 1'b1;
    logic [31:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
    logic [4:0]  rd = '0;
    logic [3:0]  alu_op = '0;
    logic        a_sel = 1'b0, b_sel = 1'b0, is_br = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
    logic [2:0]  f3 = '0;
    logic        reg_we = 1'b0, mem_re = 1'b0, mem_we = 1'b0;
    logic        ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, redir_valid;
    logic [31:0] ex_result, ex_store_data, redir_pc;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_f3;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_id_pc(pc), .i_id_rs1_data(rs1), .i_id_rs2_data(rs2), .i_id_imm(imm),
        .i_id_rd(rd), .i_id_alu_op(alu_op), .i_id_op_a_sel(a_sel), .i_id_op_b_sel(b_sel),
        .i_id_is_branch(is_br), .i_id_is_jal(is_jal), .i_id_is_jalr(is_jalr),
        .i_id_funct3(f3), .i_id_reg_we(reg_we), .i_id_mem_re(mem_re), .i_id_mem_we(mem_we),
        .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
        .o_ex_result(ex_result), .o_ex_store_data(ex_store_data), .o_ex_rd(ex_rd),
        .o_ex_reg_we(ex_reg_we), .o_ex_mem_re(ex_mem_re), .o_ex_mem_we(ex_mem_we),
        .o_ex_funct3(ex_f3), .o_redirect_valid(redir_valid), .o_redirect_pc(redir_pc)
    );

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        asel, bsel, br, jal, jalr;
        logic [2:0]  f3;
        logic        we, re, mwe;
        logic [31:0] exp_res;
        logic        exp_we, exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; rd = v.rd; alu_op = v.op;
        a_sel = v.asel; b_sel = v.bsel; is_br = v.br; is_jal = v.jal; is_jalr = v.jalr;
        f3 = v.f3; reg_we = v.we; mem_re = v.re; mem_we = v.mwe; id_valid = 1'b1;
    endtask

    task automatic add_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        vec_t v;
        v = '{32'h0, a, b, 32'h0, d, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0,
              32'h0, 1'b1, 1'b0, 32'h0};
        drive(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            pc            rs1           rs2           imm           rd  op       as bs br jl jr f3     we re mw exp_res       we rd  rpc
        vecs.push_back('{32'h0,        32'h7,        32'hFFFFFFFE, 32'h0,        5'd5, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 32'h5,        1, 0, 32'h0});
        vecs.push_back('{32'h0,        32'h5,        32'h7,        32'h0,        5'd6, 4'b1000, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 32'hFFFFFFFE, 1, 0, 32'h0});
        vecs.push_back('{32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        5'd2, 4'b0010, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 32'h1,        1, 0, 32'h0});
        vecs.push_back('{32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        5'd2, 4'b0011, 0, 0, 0, 0, 0, 3'b011, 1, 0, 0, 32'h0,        1, 0, 32'h0});
        vecs.push_back('{32'h0,        32'h80000000, 32'h0,        32'h4,        5'd3, 4'b1101, 0, 1, 0, 0, 0, 3'b101, 1, 0, 0, 32'hF8000000, 1, 0, 32'h0});
        vecs.push_back('{32'h0,        32'h80000000, 32'h0,        32'h4,        5'd3, 4'b0101, 0, 1, 0, 0, 0, 3'b101, 1, 0, 0, 32'h08000000, 1, 0, 32'h0});
        vecs.push_back('{32'h1000,     32'h0,        32'h0,        32'h5000,     5'd9, 4'b0000, 1, 1, 0, 0, 0, 3'b000, 1, 0, 0, 32'h6000,     1, 0, 32'h0});
        vecs.push_back('{32'h0,        32'h100,      32'h0,        32'hFFFFFFFC, 5'd7, 4'b0000, 0, 1, 0, 0, 0, 3'b010, 1, 1, 0, 32'hFC,       1, 0, 32'h0});
        vecs.push_back('{32'h0,        32'h200,      32'hDEADBEEF, 32'h8,        5'd0, 4'b0000, 0, 1, 0, 0, 0, 3'b010, 0, 0, 1, 32'h208,      0, 0, 32'h0});
        vecs.push_back('{32'h100,      32'hFFFFFFFF, 32'h1,        32'h20,       5'd0, 4'b0000, 0, 0, 1, 0, 0, 3'b100, 0, 0, 0, 32'h0,        0, 1, 32'h120});
        vecs.push_back('{32'h100,      32'hFFFFFFFF, 32'h1,        32'h20,       5'd0, 4'b0000, 0, 0, 1, 0, 0, 3'b110, 0, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{32'h40,       32'h5,        32'h5,        32'hFFFFFFF0, 5'd0, 4'b0000, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 32'hA,        0, 1, 32'h30});
        vecs.push_back('{32'h40,       32'h5,        32'h5,        32'hFFFFFFF0, 5'd0, 4'b0000, 0, 0, 1, 0, 0, 3'b001, 0, 0, 0, 32'hA,        0, 0, 32'h0});
        vecs.push_back('{32'h80,       32'h1,        32'hFFFFFFFF, 32'h8,        5'd0, 4'b0000, 0, 0, 1, 0, 0, 3'b101, 0, 0, 0, 32'h0,        0, 1, 32'h88});
        vecs.push_back('{32'h80,       32'h1,        32'hFFFFFFFF, 32'h8,        5'd0, 4'b0000, 0, 0, 1, 0, 0, 3'b111, 0, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{32'h80,       32'h3,        32'h3,        32'h8,        5'd0, 4'b0000, 0, 0, 1, 0, 0, 3'b010, 0, 0, 0, 32'h6,        0, 0, 32'h0});
        vecs.push_back('{32'h300,      32'h0,        32'h0,        32'h10,       5'd1, 4'b0000, 1, 1, 0, 1, 0, 3'b000, 1, 0, 0, 32'h304,      1, 1, 32'h310});
        vecs.push_back('{32'hFFFFFFFC, 32'h0,        32'h0,        32'h8,        5'd1, 4'b0000, 1, 1, 0, 1, 0, 3'b000, 1, 0, 0, 32'h0,        1, 1, 32'h4});
        vecs.push_back('{32'h200,      32'h1003,     32'h0,        32'h4,        5'd1, 4'b0000, 0, 1, 0, 0, 1, 3'b000, 1, 0, 0, 32'h204,      1, 1, 32'h1006});
        vecs.push_back('{32'h200,      32'h1003,     32'h0,        32'h4,        5'd0, 4'b0000, 0, 1, 0, 0, 1, 3'b000, 1, 0, 0, 32'h204,      0, 1, 32'h1006});

        rst = 1'b1;
        id_valid = 1'b1;
        tick; tick;
        chk("reset ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("reset redirect_valid", {31'b0, redir_valid}, 32'h0);
        chk("reset result", ex_result, 32'h0);
        chk("reset rd", {27'b0, ex_rd}, 32'h0);
        chk("reset reg_we", {31'b0, ex_reg_we}, 32'h0);
        chk("reset redirect_pc", redir_pc, 32'h0);
        id_valid = 1'b0;
        rst = 1'b0;
        tick;
        chk("idle ready", {31'b0, id_ready}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            ex_ready = 1'b1;
            tick;
            chk($sformatf("v%0d valid", i), {31'b0, ex_valid}, 32'h1);
            chk($sformatf("v%0d result", i), ex_result, vecs[i].exp_res);
            chk($sformatf("v%0d rd", i), {27'b0, ex_rd}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d reg_we", i), {31'b0, ex_reg_we}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d mem_re", i), {31'b0, ex_mem_re}, {31'b0, vecs[i].re});
            chk($sformatf("v%0d mem_we", i), {31'b0, ex_mem_we}, {31'b0, vecs[i].mwe});
            chk($sformatf("v%0d funct3", i), {29'b0, ex_f3}, {29'b0, vecs[i].f3});
            chk($sformatf("v%0d store_data", i), ex_store_data, vecs[i].rs2);
            chk($sformatf("v%0d redirect", i), {31'b0, redir_valid}, {31'b0, vecs[i].exp_redir});
            chk($sformatf("v%0d ready", i), {31'b0, id_ready}, {31'b0, !vecs[i].exp_redir});
            if (vecs[i].exp_redir)
                chk($sformatf("v%0d redirect_pc", i), redir_pc, vecs[i].exp_rpc);
            id_valid = 1'b0;
            tick;
            chk($sformatf("v%0d pulse end", i), {31'b0, redir_valid}, 32'h0);
            chk($sformatf("v%0d drain", i), {31'b0, ex_valid}, 32'h0);
        end

        // backpressure: hold ADDI result while a second instruction waits
        add_op(32'h1, 32'h0, 5'd3);
        b_sel = 1'b1; imm = 32'h2;
        tick;
        chk("bp first result", ex_result, 32'h3);
        ex_ready = 1'b0;
        add_op(32'd10, 32'd20, 5'd4);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp ready c%0d", c), {31'b0, id_ready}, 32'h0);
            tick;
            chk($sformatf("bp hold result c%0d", c), ex_result, 32'h3);
            chk($sformatf("bp hold valid c%0d", c), {31'b0, ex_valid}, 32'h1);
            chk($sformatf("bp hold rd c%0d", c), {27'b0, ex_rd}, 32'h3);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp ready released", {31'b0, id_ready}, 32'h1);
        tick;
        chk("bp second result", ex_result, 32'd30);
        chk("bp second rd", {27'b0, ex_rd}, 32'h4);
        id_valid = 1'b0;
        tick;
        chk("bp drain", {31'b0, ex_valid}, 32'h0);

        // flush while holding, with a taken jump on the input
        add_op(32'h11, 32'h22, 5'd8);
        tick;
        ex_ready = 1'b0;
        add_op(32'h0, 32'h0, 5'd1);
        is_jal = 1'b1; imm = 32'h40;
        flush = 1'b1;
        #1;
        chk("flush ready", {31'b0, id_ready}, 32'h0);
        tick;
        chk("flush valid", {31'b0, ex_valid}, 32'h0);
        chk("flush redirect", {31'b0, redir_valid}, 32'h0);
        flush = 1'b0;
        id_valid = 1'b0;
        is_jal = 1'b0;
        ex_ready = 1'b1;
        tick;
        chk("flush not accepted", {31'b0, ex_valid}, 32'h0);
        chk("flush stale rd", {27'b0, ex_rd}, 32'h8);

        // flush in the redirect cycle drops no current pulse
        add_op(32'h0, 32'h0, 5'd1);
        is_jal = 1'b1; pc = 32'h500; imm = 32'h8;
        tick;
        flush = 1'b1;
        id_valid = 1'b0;
        is_jal = 1'b0;
        chk("flush pulse current", {31'b0, redir_valid}, 32'h1);
        chk("flush pulse pc", redir_pc, 32'h508);
        tick;
        flush = 1'b0;
        chk("flush pulse gone", {31'b0, redir_valid}, 32'h0);
        chk("flush pulse valid", {31'b0, ex_valid}, 32'h0);

        // back-to-back ADDs, no bubbles
        for (int k = 0; k < 4; k++) begin
            add_op(32'(k * 10), 32'h1, 5'(k + 1));
            tick;
            chk($sformatf("b2b valid %0d", k), {31'b0, ex_valid}, 32'h1);
            chk($sformatf("b2b result %0d", k), ex_result, 32'(k * 10 + 1));
            chk($sformatf("b2b rd %0d", k), {27'b0, ex_rd}, 32'(k + 1));
        end
        add_op(32'h100, 32'h1, 5'd9);
        ex_ready = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        id_valid = 1'b0;
        chk("midrst valid", {31'b0, ex_valid}, 32'h0);
        chk("midrst result", ex_result, 32'h0);
        chk("midrst rd", {27'b0, ex_rd}, 32'h0);
        chk("midrst reg_we", {31'b0, ex_reg_we}, 32'h0);
        chk("midrst redirect", {31'b0, redir_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute pipeline stage of the RV32I core.
- Accepts decoded instructions from the ID stage over a valid/ready handshake and selects ALU operands.
- Drives the existing combinational ALU, resolves branches and jumps, and registers the result for the MEM stage.
- Issues a one-cycle PC redirect to fetch when control flow is taken.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- RD_W, 5, destination register index width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_flush  in  1  trap/kill; squashes held and incoming instructions
- i_id_valid  in  1  ID presents instruction
- o_id_ready  out  1  stage can accept
- i_id_pc  in  32  instruction PC
- i_id_rs1_data  in  32  forwarded rs1 value
- i_id_rs2_data  in  32  forwarded rs2 value
- i_id_imm  in  32  sign-extended immediate
- i_id_rd  in  5  destination register
- i_id_alu_op  in  4  {funct7[5],funct3}, ALU encoding
- i_id_op_a_sel  in  1  0: rs1, 1: pc
- i_id_op_b_sel  in  1  0: rs2, 1: imm
- i_id_is_branch  in  1  conditional branch
- i_id_is_jal  in  1  JAL
- i_id_is_jalr  in  1  JALR
- i_id_funct3  in  3  branch condition / memory size
- i_id_reg_we  in  1  writes rd
- i_id_mem_re  in  1  load
- i_id_mem_we  in  1  store
- o_ex_valid  out  1  result valid to MEM
- i_ex_ready  in  1  MEM accepts
- o_ex_result  out  32  ALU result, address, or link value
- o_ex_store_data  out  32  rs2 value
- o_ex_rd  out  5  destination register
- o_ex_reg_we  out  1  register write enable
- o_ex_mem_re  out  1  load
- o_ex_mem_we  out  1  store
- o_ex_funct3  out  3  passthrough
- o_redirect_valid  out  1  taken-branch/jump pulse
- o_redirect_pc  out  32  redirect target

Behaviour:
- Clocking: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset: o_ex_valid = 0 and o_redirect_valid = 0; every data/control output register = 0.
- Ready: o_id_ready = (!o_ex_valid || i_ex_ready) && !o_redirect_valid && !i_flush. This is combinational.
- Accept: accept = i_id_valid && o_id_ready. On accept, all outputs are loaded at the next edge; latency is 1 cycle. With no backpressure, throughput is 1 instruction/cycle.
- Operands: op_a = op_a_sel ? pc : rs1; op_b = op_b_sel ? imm : rs2.
- ALU: the ALU is instantiated internally with i_id_alu_op. ID must encode loads, stores and JALR as ADD (4'b0000).
- o_ex_result: for JAL/JALR it is pc+4 (mod 2^32); otherwise it is the ALU result.
- o_ex_store_data is rs2. o_ex_reg_we is forced to 0 when i_id_rd==0.
- Branch condition, by funct3:
  - 000 BEQ, 001 BNE: equality on rs1/rs2.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010 and 011: not taken.
- Compare path: uses its own comparator on rs1/rs2, independent of the operand selects.
- Targets:
  - Branch/JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
  - Addition wraps mod 2^32. Bit 1 is not checked; misalignment is the fetch stage's responsibility.
- Redirect: taken = accept && (is_jal || is_jalr || (is_branch && cond)).
  - o_redirect_valid is registered: high exactly the cycle after accept, for one cycle. o_redirect_pc is registered in the same edge.
  - While o_redirect_valid=1, o_id_ready=0, so the wrong-path instruction present that cycle is not consumed. Fetch/ID drop it.
- Hold: o_ex_valid=1 && !i_ex_ready holds all outputs stable. No input is accepted.
- Output handshake: if the output handshake completes with no accept in the same cycle, o_ex_valid falls to 0 at the next edge. Handshake plus accept in one cycle replaces the entry without a bubble.
- Flush: i_flush=1 clears o_ex_valid and o_redirect_valid at the next edge, overriding hold and accept. Data registers may keep stale values. A flush arriving in the same cycle as a pending redirect pulse drops the pulse for the next cycle; the current pulse is unaffected.
- Reset mid-stall: same as reset, and the pending entry is lost.
- Branches with reg_we=0 still produce a result; MEM ignores it.

Test Plan:
- ADD x5: rs1=7, rs2=0xFFFFFFFE, op_b_sel=0, alu_op=0000, rd=5, ex_ready=1 -> next cycle o_ex_valid=1, o_ex_result=5, o_ex_rd=5, o_ex_reg_we=1.
- Backpressure: accept ADDI (rs1=1, imm=2, result 3), then hold i_ex_ready=0 for 3 cycles while i_id_valid=1 -> o_id_ready=0, o_ex_result stays 3. Raise ready -> next instruction appears on the following cycle.
- BLT: pc=0x100, rs1=0xFFFFFFFF, rs2=1, funct3=100, imm=0x20 -> o_redirect_valid pulses 1 cycle, o_redirect_pc=0x120, o_id_ready=0 that cycle. Same with BLTU (110) -> no redirect.
- JALR: pc=0x200, rs1=0x1003, imm=4, rd=1 -> o_redirect_pc=0x1006, o_ex_result=0x204, o_ex_reg_we=1. Same with rd=0 -> o_ex_reg_we=0.
- Flush while o_ex_valid=1 and i_ex_ready=0, with i_id_valid=1 -> next cycle o_ex_valid=0, no redirect, input not accepted.
- Back-to-back: 4 ADDs with ready=1 throughout -> 4 consecutive valid outputs, no bubbles. Assert i_rst mid-sequence -> next cycle all outputs 0.
